// File: rtl/core_bus_pkg.sv
// Shared types and default region map for the core bus router.
// Region indices are sized for the largest supported router (8 regions).
package core_bus_pkg;

    localparam int MAX_REGIONS = 8;
    localparam int REGION_IW   = 3;

    typedef logic [REGION_IW-1:0] region_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ABORT = 2'd2
    } req_state_e;

    typedef struct packed {
        logic        pending;
        region_idx_t region;
        logic        err;
    } resp_t;

    // Region 0 = instruction/data memory at 0x1000_0000, region 1 = 0x2000_0000.
    localparam logic [1:0][31:0] DEF_REGION_BASE = {32'h2000_0000, 32'h1000_0000};
    localparam logic [1:0][31:0] DEF_REGION_MASK = {32'h0FFF_FFFF, 32'h0FFF_FFFF};

endpackage

// File: rtl/core_bus_region_dec.sv
// Combinational address decoder: one-hot hit, hit index, miss flag and the
// address rebased into the hit region. The lowest-numbered region wins on overlap.
module core_bus_region_dec
    import core_bus_pkg::*;
#(
    parameter int                                N_REGIONS   = 2,
    parameter int                                AW          = 32,
    parameter logic [N_REGIONS-1:0][AW-1:0]      REGION_BASE = DEF_REGION_BASE,
    parameter logic [N_REGIONS-1:0][AW-1:0]      REGION_MASK = DEF_REGION_MASK
) (
    input  logic [AW-1:0]        addr_i,
    output logic [N_REGIONS-1:0] hit_o,
    output region_idx_t          hit_idx_o,
    output logic                 miss_o,
    output logic [AW-1:0]        addr_o
);

    always_comb begin
        hit_o     = '0;
        hit_idx_o = '0;
        miss_o    = 1'b1;
        addr_o    = '0;
        // Walk downwards so the lowest matching index is the last one written.
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            if ((addr_i & ~REGION_MASK[i]) == REGION_BASE[i]) begin
                hit_o     = '0;
                hit_o[i]  = 1'b1;
                hit_idx_o = region_idx_t'(i);
                miss_o    = 1'b0;
                addr_o    = addr_i & REGION_MASK[i];
            end
        end
    end

endmodule

// File: rtl/core_bus_router.sv
// Routes one core req/gnt/rvalid bus onto N slave regions; unmapped accesses
// and slaves that stall past TIMEOUT cycles complete as error responses.
module core_bus_router
    import core_bus_pkg::*;
#(
    parameter int                            N_REGIONS   = 2,
    parameter int                            AW          = 32,
    parameter int                            DW          = 32,
    parameter logic [N_REGIONS-1:0][AW-1:0]  REGION_BASE = DEF_REGION_BASE,
    parameter logic [N_REGIONS-1:0][AW-1:0]  REGION_MASK = DEF_REGION_MASK,
    parameter int                            TIMEOUT     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    core_req_i,
    input  logic [AW-1:0]           core_addr_i,
    input  logic                    core_we_i,
    input  logic [DW/8-1:0]         core_be_i,
    input  logic [DW-1:0]           core_wdata_i,
    output logic                    core_gnt_o,
    output logic                    core_rvalid_o,
    output logic [DW-1:0]           core_rdata_o,
    output logic                    core_err_o,
    output logic [N_REGIONS-1:0]    slv_valid_o,
    output logic [AW-1:0]           slv_addr_o,
    output logic                    slv_write_en_o,
    output logic [DW/8-1:0]         slv_byte_en_o,
    output logic [DW-1:0]           slv_wdata_o,
    input  logic [N_REGIONS-1:0]    slv_ready_i,
    input  logic [N_REGIONS*DW-1:0] slv_rdata_i,
    input  logic                    err_clr_i,
    output logic                    bus_err_o,
    output logic [AW-1:0]           bus_err_addr_o
);

    localparam int             CW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit             TIMEOUT_EN = (TIMEOUT > 0);
    localparam logic [CW-1:0]  CNT_LAST   = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [N_REGIONS-1:0] hit;
    region_idx_t          hit_idx;
    logic                 miss;
    logic [AW-1:0]        rebased_addr;
    logic                 hit_ready;

    req_state_e           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    resp_t                resp_q, resp_d;
    logic                 bus_err_q, bus_err_d;
    logic [AW-1:0]        bus_err_addr_q, bus_err_addr_d;
    logic                 abort;
    logic                 err_now;

    core_bus_region_dec #(
        .N_REGIONS   (N_REGIONS),
        .AW          (AW),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK)
    ) u_dec (
        .addr_i    (core_addr_i),
        .hit_o     (hit),
        .hit_idx_o (hit_idx),
        .miss_o    (miss),
        .addr_o    (rebased_addr)
    );

    assign hit_ready = |(hit & slv_ready_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            resp_q         <= '0;
            bus_err_q      <= 1'b0;
            bus_err_addr_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            resp_q         <= resp_d;
            bus_err_q      <= bus_err_d;
            bus_err_addr_q <= bus_err_addr_d;
        end
    end

    // cnt_q holds the number of cycles the current request has already waited.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (core_req_i && !miss && !hit_ready) begin
                    if (TIMEOUT_EN && (CNT_LAST == '0)) begin
                        state_d = ABORT;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CW'(1);
                    end
                end
            end
            WAIT: begin
                if (hit_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    state_d = ABORT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ABORT: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        abort          = (state_q == ABORT);
        err_now        = abort | miss;
        slv_valid_o    = '0;
        core_gnt_o     = 1'b0;
        if (!rst) begin
            if (core_req_i && !abort) begin
                slv_valid_o = hit;
            end
            core_gnt_o = abort | (core_req_i & miss) | (core_req_i & hit_ready);
        end

        resp_d.pending = core_gnt_o;
        resp_d.region  = hit_idx;
        resp_d.err     = err_now;

        bus_err_d      = bus_err_q;
        bus_err_addr_d = bus_err_addr_q;
        if (core_gnt_o && err_now) begin
            bus_err_d      = 1'b1;
            bus_err_addr_d = core_addr_i;
        end else if (err_clr_i) begin
            bus_err_d = 1'b0;
        end
    end

    always_comb begin
        core_rdata_o = '0;
        if (resp_q.pending && !resp_q.err) begin
            for (int i = 0; i < N_REGIONS; i++) begin
                if (resp_q.region == region_idx_t'(i)) begin
                    core_rdata_o = slv_rdata_i[i*DW +: DW];
                end
            end
        end
    end

    assign core_rvalid_o  = resp_q.pending;
    assign core_err_o     = resp_q.pending & resp_q.err;
    assign slv_addr_o     = rebased_addr;
    assign slv_write_en_o = core_we_i;
    assign slv_byte_en_o  = core_be_i;
    assign slv_wdata_o    = core_wdata_i;
    assign bus_err_o      = bus_err_q;
    assign bus_err_addr_o = bus_err_addr_q;

endmodule

// File: tb/tb_core_bus_router.sv
// Bench for core_bus_router: directed vector table, hand-written corner
// sequences, and a randomized run against a cycle-count reference model.
module tb_core_bus_router;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              core_req_i;
    logic [AW-1:0]     core_addr_i;
    logic              core_we_i;
    logic [DW/8-1:0]   core_be_i;
    logic [DW-1:0]     core_wdata_i;
    logic              core_gnt_o;
    logic              core_rvalid_o;
    logic [DW-1:0]     core_rdata_o;
    logic              core_err_o;
    logic [N-1:0]      slv_valid_o;
    logic [AW-1:0]     slv_addr_o;
    logic              slv_write_en_o;
    logic [DW/8-1:0]   slv_byte_en_o;
    logic [DW-1:0]     slv_wdata_o;
    logic [N-1:0]      slv_ready_i;
    logic [N*DW-1:0]   slv_rdata_i;
    logic              err_clr_i;
    logic              bus_err_o;
    logic [AW-1:0]     bus_err_addr_o;

    core_bus_router #(
        .N_REGIONS (N),
        .AW        (AW),
        .DW        (DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .core_req_i     (core_req_i),
        .core_addr_i    (core_addr_i),
        .core_we_i      (core_we_i),
        .core_be_i      (core_be_i),
        .core_wdata_i   (core_wdata_i),
        .core_gnt_o     (core_gnt_o),
        .core_rvalid_o  (core_rvalid_o),
        .core_rdata_o   (core_rdata_o),
        .core_err_o     (core_err_o),
        .slv_valid_o    (slv_valid_o),
        .slv_addr_o     (slv_addr_o),
        .slv_write_en_o (slv_write_en_o),
        .slv_byte_en_o  (slv_byte_en_o),
        .slv_wdata_o    (slv_wdata_o),
        .slv_ready_i    (slv_ready_i),
        .slv_rdata_i    (slv_rdata_i),
        .err_clr_i      (err_clr_i),
        .bus_err_o      (bus_err_o),
        .bus_err_addr_o (bus_err_addr_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model of the sticky error status.
    logic          m_err  = 1'b0;
    logic [31:0]   m_addr = '0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        int          delay;   // cycle index at which the target asserts ready (255 = never)
        logic [31:0] rdata;
        logic [1:0]  mask;    // expected slv_valid_o pattern
        logic [31:0] saddr;   // expected rebased address
        logic        err;
        int          lat;     // expected cycle index of gnt
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   seen = -1;
        logic [1:0] ev;
        core_req_i   = 1'b1;
        core_addr_i  = v.addr;
        core_we_i    = v.we;
        core_be_i    = 4'hF;
        core_wdata_i = 32'h0101_0101 * idx;
        slv_rdata_i  = (v.mask == 2'b10) ? {v.rdata, ~v.rdata} : {~v.rdata, v.rdata};
        for (int c = 0; c <= 40 && seen < 0; c++) begin
            slv_ready_i = (c >= v.delay) ? v.mask : 2'b00;
            @(negedge clk);
            ev = (c < v.lat) ? v.mask : (v.err ? 2'b00 : v.mask);
            chk($sformatf("v%0d_valid_c%0d", idx, c), slv_valid_o, ev);
            if (ev != 2'b00) chk($sformatf("v%0d_saddr", idx), slv_addr_o, v.saddr);
            chk($sformatf("v%0d_gnt_c%0d", idx, c), core_gnt_o, (c == v.lat));
            if (core_gnt_o) seen = c;
            @(posedge clk); #1;
        end
        if (seen < 0) chk($sformatf("v%0d_gnt_timeout", idx), 1'b0, 1'b1);
        core_req_i  = 1'b0;
        slv_ready_i = 2'b00;
        if (v.err) begin
            m_err  = 1'b1;
            m_addr = v.addr;
        end
        @(negedge clk);
        chk($sformatf("v%0d_rvalid", idx), core_rvalid_o, 1'b1);
        chk($sformatf("v%0d_err", idx), core_err_o, v.err);
        chk($sformatf("v%0d_rdata", idx), core_rdata_o, v.err ? 32'h0 : v.rdata);
        chk($sformatf("v%0d_bus_err", idx), bus_err_o, m_err);
        chk($sformatf("v%0d_bus_err_addr", idx), bus_err_addr_o, m_addr);
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0] = '{32'h1000_0010, 1'b0, 0,   32'hDEAD_BEEF, 2'b01, 32'h0000_0010, 1'b0, 0};
        vecs[1] = '{32'h2000_0004, 1'b0, 3,   32'h1234_5678, 2'b10, 32'h0000_0004, 1'b0, 3};
        vecs[2] = '{32'h0000_0100, 1'b1, 0,   32'h1111_1111, 2'b00, 32'h0000_0000, 1'b1, 0};
        vecs[3] = '{32'h1000_0020, 1'b0, 255, 32'hCAFE_0001, 2'b01, 32'h0000_0020, 1'b1, 16};
        vecs[4] = '{32'h1000_0040, 1'b0, 0,   32'h0BAD_F00D, 2'b01, 32'h0000_0040, 1'b0, 0};
        vecs[5] = '{32'h1FFF_FFFC, 1'b1, 15,  32'h55AA_55AA, 2'b01, 32'h0FFF_FFFC, 1'b0, 15};
        vecs[6] = '{32'h2000_0100, 1'b0, 16,  32'h7777_7777, 2'b10, 32'h0000_0100, 1'b1, 16};
        vecs[7] = '{32'hF000_0000, 1'b0, 0,   32'h0000_0001, 2'b00, 32'h0000_0000, 1'b1, 0};

        // Reset: outputs quiet even with a live, ready request.
        rst          = 1'b1;
        core_req_i   = 1'b1;
        core_addr_i  = 32'h1000_0000;
        core_we_i    = 1'b0;
        core_be_i    = 4'hF;
        core_wdata_i = '0;
        slv_ready_i  = 2'b11;
        slv_rdata_i  = {32'hAAAA_AAAA, 32'h5555_5555};
        err_clr_i    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_gnt", core_gnt_o, 1'b0);
            chk("rst_valid", slv_valid_o, 2'b00);
            if (i > 0) begin
                chk("rst_rvalid", core_rvalid_o, 1'b0);
                chk("rst_err", core_err_o, 1'b0);
                chk("rst_rdata", core_rdata_o, 32'h0);
                chk("rst_bus_err", bus_err_o, 1'b0);
                chk("rst_bus_err_addr", bus_err_addr_o, 32'h0);
            end
            @(posedge clk);
        end
        #1;
        rst         = 1'b0;
        core_req_i  = 1'b0;
        slv_ready_i = 2'b00;
        @(negedge clk);
        chk("post_rst_rvalid", core_rvalid_o, 1'b0);
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Ten back-to-back zero-wait reads.
        for (int k = 0; k <= 10; k++) begin
            core_req_i  = (k < 10);
            core_addr_i = 32'h1000_0000 + 32'(4 * k);
            core_we_i   = 1'b0;
            slv_ready_i = 2'b11;
            slv_rdata_i = {32'hFFFF_0000, 32'hA000_0000 + 32'(k)};
            @(negedge clk);
            chk($sformatf("b2b_gnt_%0d", k), core_gnt_o, (k < 10));
            chk($sformatf("b2b_rvalid_%0d", k), core_rvalid_o, (k > 0));
            if (k > 0) chk($sformatf("b2b_rdata_%0d", k), core_rdata_o, 32'hA000_0000 + 32'(k));
            @(posedge clk); #1;
        end
        core_req_i  = 1'b0;
        slv_ready_i = 2'b00;
        @(negedge clk);
        chk("b2b_tail_rvalid", core_rvalid_o, 1'b0);
        @(posedge clk); #1;

        // err_clr alone clears; err_clr together with a new error leaves it set.
        err_clr_i = 1'b1;
        m_err     = 1'b0;
        @(posedge clk); #1;
        err_clr_i = 1'b0;
        @(negedge clk);
        chk("clr_bus_err", bus_err_o, 1'b0);
        @(posedge clk); #1;
        core_req_i  = 1'b1;
        core_addr_i = 32'h0000_0200;
        err_clr_i   = 1'b1;
        @(negedge clk);
        chk("clr_set_gnt", core_gnt_o, 1'b1);
        @(posedge clk); #1;
        core_req_i = 1'b0;
        err_clr_i  = 1'b0;
        m_err      = 1'b1;
        m_addr     = 32'h0000_0200;
        @(negedge clk);
        chk("clr_set_bus_err", bus_err_o, 1'b1);
        chk("clr_set_addr", bus_err_addr_o, 32'h0000_0200);
        chk("clr_set_rsp_err", core_err_o, 1'b1);
        @(posedge clk); #1;

        // Reset while waiting on a stalled slave.
        core_req_i  = 1'b1;
        core_addr_i = 32'h2000_0008;
        slv_ready_i = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rw_valid", slv_valid_o, 2'b10);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rw_rst_valid", slv_valid_o, 2'b00);
        chk("rw_rst_gnt", core_gnt_o, 1'b0);
        @(posedge clk); #1;
        rst        = 1'b0;
        core_req_i = 1'b0;
        m_err      = 1'b0;
        m_addr     = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rw_rvalid", core_rvalid_o, 1'b0);
            chk("rw_bus_err", bus_err_o, 1'b0);
            @(posedge clk); #1;
        end
        run_vec(vecs[3], 30);
        run_vec(vecs[0], 31);

        // Randomized traffic against the cycle-count reference model.
        begin
            bit          active = 0, unm = 0, stall = 0;
            int          region = 0, waited = 0, kind, nib;
            logic [31:0] raddr  = '0;
            bit          pg = 0, pe = 0;
            int          pr = 0;
            logic [1:0]  rdy, ev;
            bit          eg, ee;
            for (int cyc = 0; cyc < 2000; cyc++) begin
                if (!active && $urandom_range(0, 3) != 0) begin
                    kind   = $urandom_range(0, 9);
                    active = 1;
                    waited = 0;
                    stall  = ($urandom_range(0, 5) == 0);
                    unm    = 0;
                    region = 0;
                    if (kind < 4) begin
                        raddr = 32'h1000_0000 | ($urandom & 32'h0FFF_FFFF);
                    end else if (kind < 8) begin
                        region = 1;
                        raddr  = 32'h2000_0000 | ($urandom & 32'h0FFF_FFFF);
                    end else begin
                        unm = 1;
                        nib = $urandom_range(0, 13);
                        if (nib >= 1) nib += 2;
                        raddr = (32'(nib) << 28) | ($urandom & 32'h0FFF_FFFF);
                    end
                    core_we_i    = 1'($urandom_range(0, 1));
                    core_be_i    = 4'($urandom);
                    core_wdata_i = $urandom;
                end
                core_req_i  = active;
                core_addr_i = active ? raddr : $urandom;
                rdy         = 2'($urandom_range(0, 3));
                if (active && !unm && stall && waited < TO) rdy[region] = 1'b0;
                slv_ready_i = rdy;
                slv_rdata_i = {$urandom, $urandom};
                err_clr_i   = ($urandom_range(0, 15) == 0);
                @(negedge clk);
                ev = 2'b00;
                eg = 0;
                ee = 0;
                if (active) begin
                    if (unm || waited == TO) begin
                        eg = 1;
                        ee = 1;
                    end else begin
                        ev[region] = 1'b1;
                        eg = rdy[region];
                    end
                end
                chk("rnd_gnt", core_gnt_o, eg);
                chk("rnd_valid", slv_valid_o, ev);
                if (ev != 2'b00) begin
                    chk("rnd_saddr", slv_addr_o, raddr & 32'h0FFF_FFFF);
                    chk("rnd_we", slv_write_en_o, core_we_i);
                end
                chk("rnd_rvalid", core_rvalid_o, pg);
                if (pg) begin
                    chk("rnd_err", core_err_o, pe);
                    chk("rnd_rdata", core_rdata_o, pe ? 32'h0 : slv_rdata_i[pr*32 +: 32]);
                end
                chk("rnd_bus_err", bus_err_o, m_err);
                chk("rnd_bus_err_addr", bus_err_addr_o, m_addr);
                if (eg && ee) begin
                    m_err  = 1'b1;
                    m_addr = raddr;
                end else if (err_clr_i) begin
                    m_err = 1'b0;
                end
                pg = eg;
                pe = ee;
                pr = region;
                if (eg) active = 0;
                else if (active) waited++;
                @(posedge clk); #1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_bus_router.md
# core_bus_router

Parametrised successor to the single-port core memory glue: routes one core-side req/gnt/rvalid data or instruction bus onto N MemPort-style slave regions. It decodes the address, rebases it, and generates rvalid/rdata/err back to the core. Unmapped addresses and stalled slaves (timeout) complete as bus errors instead of hanging the core. It sits between zeroriscy_core and the instruction/data memories plus the debug region, one instance per core bus.

## Interface
Parameters:
- N_REGIONS, 2, number of slave regions (1..8)
- AW, 32, address width
- DW, 32, data width (multiple of 8)
- REGION_BASE, {32'h2000_0000, 32'h1000_0000}, per-region base address, packed [N_REGIONS][AW]; index 0 is the LSB slice
- REGION_MASK, {32'h0FFF_FFFF, 32'h0FFF_FFFF}, per-region offset mask, packed [N_REGIONS][AW]; regions are power-of-two sized and aligned
- TIMEOUT, 16, cycles a slave may hold off ready; 0 disables the timeout

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- core_req_i  in  1  core request; held stable with its attributes until gnt
- core_addr_i  in  AW  request address
- core_we_i  in  1  write enable
- core_be_i  in  DW/8  byte enables
- core_wdata_i  in  DW  write data
- core_gnt_o  out  1  request accepted this cycle
- core_rvalid_o  out  1  response valid
- core_rdata_o  out  DW  read data; valid only with rvalid
- core_err_o  out  1  response is an error; valid only with rvalid
- slv_valid_o  out  N_REGIONS  per-region request
- slv_addr_o  out  AW  rebased address, shared by all regions
- slv_write_en_o  out  1  shared write enable
- slv_byte_en_o  out  DW/8  shared byte enables
- slv_wdata_o  out  DW  shared write data
- slv_ready_i  in  N_REGIONS  per-region accept
- slv_rdata_i  in  N_REGIONS*DW  per-region read data, valid the cycle after ready
- err_clr_i  in  1  clears the sticky error status
- bus_err_o  out  1  sticky: some error response has occurred
- bus_err_addr_o  out  AW  core address of the most recent error

## Operation
- Decode: region i hits when (core_addr_i & ~REGION_MASK[i]) == REGION_BASE[i]. On overlap, the lowest index wins. slv_addr_o = core_addr_i & REGION_MASK[hit].
- Request FSM states:
  - IDLE: no cycles waited.
  - WAIT: slave valid asserted, not yet ready; cycle counter running.
  - ABORT: timeout reached.
- slv_valid_o[hit] = core_req_i & hit & (state != ABORT). All other bits are 0.
- core_gnt_o:
  - hit region asserts ready, or
  - core_req_i with no hit (decode error), or
  - state ABORT.
- Transitions:
  - IDLE -> WAIT on req & hit & !ready.
  - WAIT -> IDLE on ready.
  - WAIT -> ABORT when the counter reaches TIMEOUT-1 and there is still no ready.
  - ABORT -> IDLE unconditionally (its gnt consumes the request).
- Response register, loaded on every gnt: resp_pending=1, resp_region, and resp_err (decode error or abort).
  - Next cycle: core_rvalid_o=1.
  - core_rdata_o = resp_err ? 0 : slv_rdata_i[resp_region].
- Error side effects: every error response sets bus_err_o and loads bus_err_addr_o.
  - err_clr_i clears bus_err_o.
  - If err_clr_i and a new error coincide, the set wins.
- Writes to an unmapped address or to a timed-out region are dropped. The slave never sees valid for the unmapped case.

## Timing
- Zero-wait slave: req and ready in cycle T -> gnt in T, rvalid in T+1. Back-to-back: a new gnt in T+1 alongside the rvalid gives throughput of 1/cycle.
- Unmapped: gnt in T, rvalid+err in T+1, rdata=0.
- Slow slave: valid from T; ready in T+k with k < TIMEOUT -> gnt in T+k, rvalid in T+k+1.
- Timeout: no ready during T..T+TIMEOUT-1 -> ABORT in T+TIMEOUT with slv_valid low and gnt high -> rvalid+err in T+TIMEOUT+1. A ready that arrives during ABORT is ignored.
- TIMEOUT=0: WAIT never exits except on ready.
- Counter width is $clog2(TIMEOUT+1); it clears on leaving WAIT.
- Reset values:
  - core_gnt_o=0, core_rvalid_o=0, core_err_o=0, core_rdata_o=0
  - slv_valid_o=0 (forced while rst)
  - bus_err_o=0, bus_err_addr_o=0
  - FSM=IDLE, counter=0
- Reset mid-operation drops any pending response. No rvalid appears in the cycle after reset deasserts.

## Structure
- Package core_bus_pkg:
  - req_state_e {IDLE, WAIT, ABORT}
  - resp_t {pending, region, err}
  - default base/mask constants
- Sub-module core_bus_region_dec: combinational address decoder producing a hit one-hot, a hit index, a miss flag and the rebased address.

## Test plan
- Zero-wait read of 0x1000_0010, region0 rdata=0xDEADBEEF -> slv_valid_o=01, slv_addr_o=0x10, gnt T, rvalid T+1 with rdata 0xDEADBEEF, err=0.
- Read of 0x2000_0004 with region1 ready after 3 cycles -> gnt T+3, rvalid T+4, slv_addr_o=0x4, region0 valid never asserted.
- Write to 0x0000_0100 (unmapped) -> no slv_valid_o, gnt T, rvalid+err T+1, rdata 0, bus_err_o=1, bus_err_addr_o=0x0000_0100.
- TIMEOUT=16, region0 never ready -> slv_valid_o high for exactly 16 cycles, gnt T+16, err rvalid T+17; next request to region0 is accepted normally.
- Ten back-to-back zero-wait reads -> gnt every cycle, rvalid every cycle from T+1, data in order; err_clr_i coinciding with a new error leaves bus_err_o=1.
- Assert rst while in WAIT -> slv_valid_o=0 in the reset cycle, FSM IDLE, no rvalid emitted after release.
